// File: rtl/load_store_unit.sv
// load_store_unit: turns one core-side byte-addressed load/store into a
// single word-indexed data-cache request. It builds the byte mask and
// lane-aligned store data, waits for the cache completion pulse or a timeout,
// and returns a sign/zero-extended load result with a one-cycle done pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the cache and complete at
//               once with cpu_misalign=1 and cpu_rdata=0.
//   undefined : misaligned low address bits are forced aligned and
//               cpu_misalign stays 0.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              cpu_misalign,
  output logic              dc_request,
  output logic              dc_we,
  output logic              dc_re,
  output logic              dc_load,
  output logic [3:0]        dc_mask,
  output logic [ADDR_W-1:0] dc_address,
  output logic [31:0]       dc_data_in,
  input  logic              dc_valid,
  input  logic [31:0]       dc_data_out
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Counter only has to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             we_lat;
  logic [2:0]       funct3_lat;
  logic [1:0]       addr_lo;

  // Address bits above the word index never reach the cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

  // Byte-lane mask; misaligned low bits are ignored (forced aligned).
  function automatic logic [3:0] calc_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate the right-aligned store data across every lane of its size.
  function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half from the cache word and extend it.
  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Half with a[0] set, or word with any low bit set, is misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      we_lat       <= 1'b0;
      funct3_lat   <= 3'b000;
      addr_lo      <= 2'b00;
      cpu_ready    <= 1'b1;
      cpu_done     <= 1'b0;
      cpu_rdata    <= 32'h0000_0000;
      cpu_err      <= 1'b0;
      cpu_misalign <= 1'b0;
      dc_request   <= 1'b0;
      dc_we        <= 1'b0;
      dc_re        <= 1'b0;
      dc_load      <= 1'b0;
      dc_mask      <= 4'b0000;
      dc_address   <= '0;
      dc_data_in   <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_done <= 1'b0;
          if (cpu_req) begin
            we_lat       <= cpu_we;
            funct3_lat   <= cpu_funct3;
            addr_lo      <= cpu_addr[1:0];
            cpu_ready    <= 1'b0;
            cpu_err      <= 1'b0;
            cpu_misalign <= 1'b0;
            cpu_rdata    <= 32'h0000_0000;
            if (TRAP_EN && is_misaligned(cpu_funct3, cpu_addr[1:0])) begin
              // Cache is never touched; complete straight away.
              cpu_misalign <= 1'b1;
              cpu_done     <= 1'b1;
              state        <= S_DONE;
            end else begin
              dc_request <= 1'b1;
              dc_we      <= cpu_we;
              dc_re      <= ~cpu_we;
              dc_load    <= ~cpu_we;
              dc_mask    <= calc_mask(cpu_funct3, cpu_addr[1:0]);
              dc_address <= cpu_addr[ADDR_W+1:2];
              dc_data_in <= calc_wdata(cpu_funct3, cpu_wdata);
              state      <= S_ISSUE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          dc_request <= 1'b0;
          wait_cnt   <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (dc_valid) begin
            cpu_rdata <= we_lat ? 32'h0000_0000 : format_load(funct3_lat, addr_lo, dc_data_out);
            cpu_done  <= 1'b1;
            dc_we     <= 1'b0;
            dc_re     <= 1'b0;
            dc_load   <= 1'b0;
            state     <= S_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cpu_rdata <= 32'h0000_0000;
            cpu_err   <= 1'b1;
            cpu_done  <= 1'b1;
            dc_we     <= 1'b0;
            dc_re     <= 1'b0;
            dc_load   <= 1'b0;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          cpu_done  <= 1'b0;
          cpu_ready <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_IDLE;
        end
        default: begin
          dc_request <= 1'b0;
          cpu_done   <= 1'b0;
          cpu_ready  <= 1'b1;
          wait_cnt   <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small cache model
// whose response latency is set per transaction (0 = never responds).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        cpu_misalign;
  logic        dc_request;
  logic        dc_we;
  logic        dc_re;
  logic        dc_load;
  logic [3:0]  dc_mask;
  logic [7:0]  dc_address;
  logic [31:0] dc_data_in;
  logic        dc_valid;
  logic [31:0] dc_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(15), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .cpu_misalign(cpu_misalign),
    .dc_request(dc_request), .dc_we(dc_we), .dc_re(dc_re), .dc_load(dc_load),
    .dc_mask(dc_mask), .dc_address(dc_address), .dc_data_in(dc_data_in),
    .dc_valid(dc_valid), .dc_data_out(dc_data_out)
  );

  // ---------------- cache model ----------------
  logic [31:0] mem [0:255];
  int          lat;
  int          pend;
  logic        fire;

  always_comb fire = dc_request ? (lat == 1) : (pend == 1);

  always @(posedge clk) begin
    if (rst) begin
      dc_valid    <= 1'b0;
      dc_data_out <= 32'h0;
      pend        <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else begin
      dc_valid <= 1'b0;
      if (fire) begin
        dc_valid    <= 1'b1;
        dc_data_out <= mem[dc_address];
        if (dc_we)
          for (int i = 0; i < 4; i++)
            if (dc_mask[i]) mem[dc_address][8*i +: 8] <= dc_data_in[8*i +: 8];
      end
      if (dc_request) pend <= (lat > 1) ? lat - 1 : 0;
      else if (pend > 0) pend <= pend - 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_din;
    logic [7:0]  exp_daddr;
    int          exp_lat;
    logic        exp_err;
    logic        exp_mis;
    int          exp_req;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int l, input logic [31:0] rd, input logic [3:0] m,
                     input logic [31:0] din, input logic [7:0] da, input int el, input logic er,
                     input logic mi, input int rq);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.lat = l;
    v.exp_rdata = rd; v.exp_mask = m; v.exp_din = din; v.exp_daddr = da;
    v.exp_lat = el; v.exp_err = er; v.exp_mis = mi; v.exp_req = rq;
    vecs.push_back(v);
  endtask

  // Results of the most recent transaction
  int          r_idx;
  int          r_reqs;
  logic [3:0]  r_mask;
  logic [7:0]  r_daddr;
  logic [31:0] r_din;
  logic        r_we;
  logic        r_re;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_mis;

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cpu_ready; i++) @(posedge clk);
  endtask

  // Issue one request; sample #1 after each edge (index 1 = first cycle after accept).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int l);
    wait_ready();
    lat = l;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    r_idx = 0; r_reqs = 0;
    r_mask = 4'h0; r_daddr = 8'h0; r_din = 32'h0; r_we = 1'b0; r_re = 1'b0;
    r_rdata = 32'hx; r_err = 1'bx; r_mis = 1'bx;
    for (int idx = 1; idx <= 40; idx++) begin
      if (dc_request) begin
        r_reqs++;
        r_mask = dc_mask; r_daddr = dc_address; r_din = dc_data_in; r_we = dc_we; r_re = dc_re;
      end
      if (cpu_done) begin
        r_idx = idx; r_rdata = cpu_rdata; r_err = cpu_err; r_mis = cpu_misalign;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int ndone;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'b000;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; lat = 1;

    //   name       we f3      addr          wdata         lat rdata         mask     din           daddr  lat err mis req
    add("sw_10",    1, 3'b010, 32'h10,       32'hDEADBEEF, 1, 32'h0,        4'b1111, 32'hDEADBEEF, 8'h04, 3,  0,  0,  1);
    add("lw_10",    0, 3'b010, 32'h10,       32'h0,        1, 32'hDEADBEEF, 4'b1111, 32'h0,        8'h04, 3,  0,  0,  1);
    add("lw_miss",  0, 3'b010, 32'h10,       32'h0,        3, 32'hDEADBEEF, 4'b1111, 32'h0,        8'h04, 5,  0,  0,  1);
    add("sw_20",    1, 3'b010, 32'h20,       32'h80FF7F01, 1, 32'h0,        4'b1111, 32'h80FF7F01, 8'h08, 3,  0,  0,  1);
    add("lb_21",    0, 3'b000, 32'h21,       32'h0,        1, 32'h0000007F, 4'b0010, 32'h0,        8'h08, 3,  0,  0,  1);
    add("lb_23",    0, 3'b000, 32'h23,       32'h0,        1, 32'hFFFFFF80, 4'b1000, 32'h0,        8'h08, 3,  0,  0,  1);
    add("lbu_22",   0, 3'b100, 32'h22,       32'h0,        1, 32'h000000FF, 4'b0100, 32'h0,        8'h08, 3,  0,  0,  1);
    add("sh_32",    1, 3'b001, 32'h32,       32'h1234A5C3, 1, 32'h0,        4'b1100, 32'hA5C3A5C3, 8'h0C, 3,  0,  0,  1);
    add("lh_32",    0, 3'b001, 32'h32,       32'h0,        1, 32'hFFFFA5C3, 4'b1100, 32'h0,        8'h0C, 3,  0,  0,  1);
    add("lhu_32",   0, 3'b101, 32'h32,       32'h0,        1, 32'h0000A5C3, 4'b1100, 32'h0,        8'h0C, 3,  0,  0,  1);
    add("sb_31",    1, 3'b000, 32'h31,       32'hFFFFFF5A, 1, 32'h0,        4'b0010, 32'h5A5A5A5A, 8'h0C, 3,  0,  0,  1);
    add("lw_30",    0, 3'b010, 32'h30,       32'h0,        1, 32'hA5C35A00, 4'b1111, 32'h0,        8'h0C, 3,  0,  0,  1);
    add("lw_hiadr", 0, 3'b010, 32'hFFFFFC10, 32'h0,        1, 32'hDEADBEEF, 4'b1111, 32'h0,        8'h04, 3,  0,  0,  1);
`ifdef LSU_MISALIGN_TRAP_EN
    add("lw_13",    0, 3'b010, 32'h13,       32'h0,        1, 32'h0,        4'b0000, 32'h0,        8'h00, 1,  0,  1,  0);
    add("lh_33",    0, 3'b001, 32'h33,       32'h0,        1, 32'h0,        4'b0000, 32'h0,        8'h00, 1,  0,  1,  0);
`else
    add("lw_13",    0, 3'b010, 32'h13,       32'h0,        1, 32'hDEADBEEF, 4'b1111, 32'h0,        8'h04, 3,  0,  0,  1);
    add("lh_33",    0, 3'b001, 32'h33,       32'h0,        1, 32'hFFFFA5C3, 4'b1100, 32'h0,        8'h0C, 3,  0,  0,  1);
`endif
    add("timeout",  0, 3'b010, 32'h10,       32'h0,        0, 32'h0,        4'b1111, 32'h0,        8'h04, 17, 1,  0,  1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, cpu_ready}, 32'h1);
    chk("rst_done", {31'h0, cpu_done}, 32'h0);
    chk("rst_dcreq", {31'h0, dc_request}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_errmis", {30'h0, cpu_err, cpu_misalign}, 32'h0);
    chk("rst_dcctl", {28'h0, dc_we, dc_re, dc_load, 1'b0}, 32'h0);
    chk("rst_mask", {28'h0, dc_mask}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven transactions
    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].lat);
      chk({vecs[i].name, "_lat"}, r_idx, vecs[i].exp_lat);
      chk({vecs[i].name, "_rdata"}, r_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, {31'h0, r_err}, {31'h0, vecs[i].exp_err});
      chk({vecs[i].name, "_mis"}, {31'h0, r_mis}, {31'h0, vecs[i].exp_mis});
      chk({vecs[i].name, "_nreq"}, r_reqs, vecs[i].exp_req);
      if (vecs[i].exp_req != 0) begin
        chk({vecs[i].name, "_mask"}, {28'h0, r_mask}, {28'h0, vecs[i].exp_mask});
        chk({vecs[i].name, "_daddr"}, {24'h0, r_daddr}, {24'h0, vecs[i].exp_daddr});
        chk({vecs[i].name, "_din"}, r_din, vecs[i].exp_din);
        chk({vecs[i].name, "_were"}, {30'h0, r_we, r_re}, {30'h0, vecs[i].we, ~vecs[i].we});
      end
      @(posedge clk); #1;
      chk({vecs[i].name, "_ready_after"}, {30'h0, cpu_ready, cpu_done}, 32'h2);
    end

    // Reset while in WAIT: transaction dropped, no done
    wait_ready();
    lat = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h10;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstwait_ready", {31'h0, cpu_ready}, 32'h1);
    chk("rstwait_dcreq", {31'h0, dc_request}, 32'h0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (cpu_done) ndone++;
    end
    chk("rstwait_nodone", ndone, 0);

    // Reset in ISSUE: dc_request drops on the next edge
    lat = 1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h10;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("issue_dcreq", {31'h0, dc_request}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstissue_dcreq", {31'h0, dc_request}, 32'h0);
    chk("rstissue_ready", {31'h0, cpu_ready}, 32'h1);
    rst = 1'b0;

    // cpu_req held while busy: exactly one completion
    lat = 3;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h10;
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (k == 3) cpu_req = 1'b0;
      if (cpu_done) ndone++;
    end
    chk("overlap_one_done", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data cache and converts a core-side byte-addressed load/store into one word-indexed cache request.
- Store path: generates the byte mask, shifts store data into the correct lanes, drives the request, then waits for the cache valid pulse or a timeout.
- Load path: extracts the addressed byte/half/word, then sign- or zero-extends it.
- Result is returned to the core as a single-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles spent in WAIT before aborting with cpu_err; must be ≥ 4.
- ADDR_W, 8: width of the cache word index. Driven from cpu_addr[ADDR_W+1:2].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  start transaction; sampled only while cpu_ready=1
- cpu_we  in  1  1=store, 0=load
- cpu_funct3  in  3  RV32 funct3: [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_ready  out  1  block idle, can accept
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  extended load result, valid with cpu_done
- cpu_err  out  1  timeout flag, valid with cpu_done
- cpu_misalign  out  1  misaligned-access flag, valid with cpu_done
- dc_request  out  1  one-cycle request pulse to cache
- dc_we  out  1  cache write enable
- dc_re  out  1  cache read enable
- dc_load  out  1  equals dc_re
- dc_mask  out  4  byte-lane mask
- dc_address  out  ADDR_W  word index
- dc_data_in  out  32  lane-aligned store data
- dc_valid  in  1  cache completion pulse
- dc_data_out  in  32  cache read word

Behaviour:
- Reset values: all outputs registered; reset drives all to 0 except cpu_ready=1; state=IDLE; timeout counter=0.
- Reset mid-transaction: the transaction is dropped silently, no cpu_done is produced, and dc_request drops next edge.
- State machine: IDLE, ISSUE, WAIT, DONE.
- IDLE: when cpu_req=1, latch cpu_we/cpu_funct3/cpu_addr/cpu_wdata, set cpu_ready=0, then go to ISSUE. When cpu_req=0, stay.
- ISSUE: exactly one cycle with dc_request=1. Drive dc_we=cpu_we, dc_re=dc_load=~cpu_we. Go to WAIT.
- Stable cache inputs: dc_address, dc_mask, dc_data_in, dc_we and dc_re are held constant from ISSUE until leaving WAIT. The cache uses address during its fetch.
- WAIT: dc_request=0, counter increments each cycle. dc_valid is sampled only in this state.
  - On dc_valid=1: capture the formatted result into cpu_rdata (stores give 0), then go to DONE.
  - If the counter reaches TIMEOUT_CYCLES first: cpu_rdata=0, cpu_err=1, then go to DONE.
- DONE: cpu_done=1 for one cycle, cpu_ready=1 on the next edge, state goes to IDLE, counter is cleared. cpu_err and cpu_misalign clear when the next request is accepted.
- cpu_req while busy is ignored; there is no queueing.
- Latency from accept edge T:
  - dc_request high in T+1.
  - Hit or store: dc_valid in T+2, cpu_done in T+3.
  - Miss (cache takes 2 extra cycles): cpu_done in T+5.
- Mask by size and addr[1:0]:
  - Byte: 0001<<a[1:0].
  - Half: 0011<<(2*a[1]).
  - Word: 1111.
- Store data:
  - Byte: wdata[7:0] replicated ×4.
  - Half: wdata[15:0] replicated ×2.
  - Word: as-is.
- Load extraction:
  - Byte: select lane a[1:0], sign-extend when funct3[2]=0, else zero-extend.
  - Half: select half a[1], same extension rule.
  - Word: full word; funct3[2] is ignored.
- dc_address = cpu_addr[ADDR_W+1:2]. Address bits above that range are ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with a[0]=1 or a word access with a[1:0]≠0 never enters ISSUE. IDLE goes straight to DONE, so cpu_done arrives at T+1 with cpu_misalign=1 and cpu_rdata=0. No dc_request is issued and the cache is untouched.
- Undefined: misaligned low bits are forced aligned. Half uses a[1] only; word ignores a[1:0]. cpu_misalign is tied 0.

Test Plan:
- Store then load, same address: SW 0xDEADBEEF at addr 0x10, then LW from 0x10. Required: store has dc_mask=1111, dc_address=0x04, dc_request for exactly 1 cycle, cpu_done at T+3; load returns cpu_rdata=0xDEADBEEF.
- Byte loads: word 0x80FF7F01 at addr 0x20. LB@0x21 → 0x0000007F; LB@0x23 → 0xFFFFFF80; LBU@0x22 → 0x000000FF.
- Half store/load: SH 0xA5C3 at addr 0x32. Required: dc_mask=1100, dc_data_in=0xA5C3A5C3. Then LH@0x32 → 0xFFFFA5C3 and LHU@0x32 → 0x0000A5C3.
- Miss latency: a cache model that delays dc_valid 3 cycles after request gives cpu_done at T+5. A model that never asserts dc_valid gives cpu_err=1, cpu_rdata=0 after 15 WAIT cycles, followed by cpu_ready=1.
- Reset/overlap: assert rst in WAIT → no cpu_done, cpu_ready=1 and dc_request=0 after the edge. A cpu_req pulse while busy is ignored (exactly one done per accepted request).
- Misalign: LW@0x13 with LSU_MISALIGN_TRAP_EN → cpu_done at T+1, cpu_misalign=1, no dc_request. Without the macro → dc_address=0x04, dc_mask=1111, normal completion.
